sinina_and_codec: RTL and testbench

Encoder/decoder front end for the 2-share, triplicated (1-1 SININA) masked AND gadget. It accepts one plain operand pair per transaction and splits each bit into two Boolean shares with caller-supplied mask bits. It replicates every share 3×, drives the gadget, and waits out the gadget's pipeline latency. It then majority-decodes and unmasks the returned shares, flagging any replica disagreement, and sits between the test/driver logic and the gadget instance.

---
 rtl/sinina_codec_pkg.sv | 27 ++
 rtl/sinina_and_codec_if.sv | 24 ++
 rtl/sinina_maj3_dec.sv | 13 +
 rtl/sinina_and_codec.sv | 137 +++++++++++++
 tb/tb_sinina_and_codec.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/sinina_codec_pkg.sv
// Shared definitions for the SININA AND-gadget codec: replication factor,
// FSM state encoding and the share encoder.
package sinina_codec_pkg;

    localparam int REP = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        HOLD  = 2'd2
    } state_e;

    // Two replicated Boolean shares of one plain bit.
    typedef struct packed {
        logic [REP-1:0] s0;
        logic [REP-1:0] s1;
    } share_pair_t;

    // Split a bit into (bit^mask, mask), each replicated REP times.
    function automatic share_pair_t encode(input logic b, input logic m);
        share_pair_t r;
        r.s0 = {REP{b ^ m}};
        r.s1 = {REP{m}};
        return r;
    endfunction

endpackage

// File: rtl/sinina_and_codec_if.sv
// Upstream operand handshake and downstream result handshake of the codec.
interface sinina_and_codec_if;
    logic       in_valid;
    logic       in_ready;
    logic       in_a;
    logic       in_b;
    logic [1:0] in_m;
    logic       out_valid;
    logic       out_ready;
    logic       out_c;
    logic       out_fault;

    // Driver / consumer side
    modport master (
        output in_valid, in_a, in_b, in_m, out_ready,
        input  in_ready, out_valid, out_c, out_fault
    );

    // Codec side
    modport slave (
        input  in_valid, in_a, in_b, in_m, out_ready,
        output in_ready, out_valid, out_c, out_fault
    );
endinterface

// File: rtl/sinina_maj3_dec.sv
// Combinational 2-of-3 majority vote with a flag raised when the three
// replicas do not all agree.
module sinina_maj3_dec (
    input  logic [2:0] v,
    output logic       maj,
    output logic       disagree
);
    // Majority and disagreement are pure functions of the triple
    always_comb begin
        maj      = (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
        disagree = (v != 3'b000) && (v != 3'b111);
    end
endmodule

// File: rtl/sinina_and_codec.sv
// Encoder/decoder wrapped around a triplicated 2-share masked AND gadget:
// masks and replicates one operand pair, waits out the gadget pipeline,
// then majority-decodes, unmasks and reports replica disagreement.
module sinina_and_codec
    import sinina_codec_pkg::*;
#(
    parameter int LATENCY = 3,
    parameter int CNT_W   = 8
) (
    input  logic              clk,
    input  logic              reset,
    sinina_and_codec_if.slave io,
    output logic [REP-1:0]    gad_a_0,
    output logic [REP-1:0]    gad_a_1,
    output logic [REP-1:0]    gad_b_0,
    output logic [REP-1:0]    gad_b_1,
    input  logic [REP-1:0]    gad_c_0,
    input  logic [REP-1:0]    gad_c_1,
    output logic [CNT_W-1:0]  fault_cnt,
    output logic              alarm
);

    localparam logic [1:0] S_IDLE  = 2'(IDLE);
    localparam logic [1:0] S_DRIVE = 2'(DRIVE);
    localparam logic [1:0] S_HOLD  = 2'(HOLD);
    localparam int         CW      = $clog2(LATENCY + 1);

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    share_pair_t      sh_a_q, sh_a_d;
    share_pair_t      sh_b_q, sh_b_d;
    logic             out_valid_q, out_valid_d;
    logic             out_c_q, out_c_d;
    logic             out_fault_q, out_fault_d;
    logic [CNT_W-1:0] fault_cnt_q, fault_cnt_d;
    logic             alarm_q, alarm_d;

    logic d0, d1, dis0, dis1, cap_fault;

    sinina_maj3_dec u_dec_c0 (.v(gad_c_0), .maj(d0), .disagree(dis0));
    sinina_maj3_dec u_dec_c1 (.v(gad_c_1), .maj(d1), .disagree(dis1));

    assign cap_fault = dis0 | dis1;

    // Next-state: accept in IDLE, count out the gadget latency in DRIVE,
    // capture the decoded result when the count expires, hold until taken.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sh_a_d      = sh_a_q;
        sh_b_d      = sh_b_q;
        out_valid_d = out_valid_q;
        out_c_d     = out_c_q;
        out_fault_d = out_fault_q;
        fault_cnt_d = fault_cnt_q;
        alarm_d     = alarm_q;
        case (state_q)
            S_IDLE: begin
                if (io.in_valid) begin
                    state_d = S_DRIVE;
                    cnt_d   = CW'(LATENCY);
                    sh_a_d  = encode(io.in_a, io.in_m[0]);
                    sh_b_d  = encode(io.in_b, io.in_m[1]);
                end
            end
            S_DRIVE: begin
                if (cnt_q == '0) begin
                    // Shares drop to zero as soon as the gadget result is taken
                    state_d     = S_HOLD;
                    sh_a_d      = '0;
                    sh_b_d      = '0;
                    out_valid_d = 1'b1;
                    out_c_d     = d0 ^ d1;
                    out_fault_d = cap_fault;
                    if (cap_fault) begin
                        alarm_d = 1'b1;
                        if (fault_cnt_q != '1) begin
                            fault_cnt_d = fault_cnt_q + CNT_W'(1);
                        end
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_HOLD: begin
                if (io.out_ready) begin
                    state_d     = S_IDLE;
                    out_valid_d = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers; an asserted reset abandons any in-flight operation
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            sh_a_q      <= '0;
            sh_b_q      <= '0;
            out_valid_q <= 1'b0;
            out_c_q     <= 1'b0;
            out_fault_q <= 1'b0;
            fault_cnt_q <= '0;
            alarm_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sh_a_q      <= sh_a_d;
            sh_b_q      <= sh_b_d;
            out_valid_q <= out_valid_d;
            out_c_q     <= out_c_d;
            out_fault_q <= out_fault_d;
            fault_cnt_q <= fault_cnt_d;
            alarm_q     <= alarm_d;
        end
    end

    // Output mapping; shares come straight from registers so they are
    // glitch-free toward the gadget
    always_comb begin
        io.in_ready  = (state_q == S_IDLE);
        io.out_valid = out_valid_q;
        io.out_c     = out_c_q;
        io.out_fault = out_fault_q;
        gad_a_0      = sh_a_q.s0;
        gad_a_1      = sh_a_q.s1;
        gad_b_0      = sh_b_q.s0;
        gad_b_1      = sh_b_q.s1;
        fault_cnt    = fault_cnt_q;
        alarm        = alarm_q;
    end

endmodule

// File: tb/tb_sinina_and_codec.sv
// Directed bench for sinina_and_codec with a behavioural 3-stage masked
// AND gadget and injectable replica bit-flips on the result shares.
module tb_sinina_and_codec;
    localparam int LAT = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [2:0] gad_a_0, gad_a_1, gad_b_0, gad_b_1;
    logic [2:0] gad_c_0, gad_c_1;
    logic [7:0] fault_cnt;
    logic       alarm;
    logic [2:0] flip0 = 3'b000;
    logic [2:0] flip1 = 3'b000;

    int checks = 0;
    int errors = 0;

    sinina_and_codec_if bus ();

    sinina_and_codec #(.LATENCY(LAT), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .io(bus),
        .gad_a_0(gad_a_0), .gad_a_1(gad_a_1),
        .gad_b_0(gad_b_0), .gad_b_1(gad_b_1),
        .gad_c_0(gad_c_0), .gad_c_1(gad_c_1),
        .fault_cnt(fault_cnt), .alarm(alarm)
    );

    always #5 clk = ~clk;

    // Behavioural gadget: c0^c1 = (a0^a1)&(b0^b1), refreshed by z, LAT stages
    logic [2:0] p_c0 [LAT];
    logic [2:0] p_c1 [LAT];
    logic       z = 1'b0;
    always @(posedge clk) begin
        z       <= ~z;
        p_c0[0] <= (gad_a_0 & gad_b_0) ^ (gad_a_0 & gad_b_1) ^ {3{z}};
        p_c1[0] <= (gad_a_1 & gad_b_0) ^ (gad_a_1 & gad_b_1) ^ {3{z}};
        for (int i = 1; i < LAT; i++) begin
            p_c0[i] <= p_c0[i-1];
            p_c1[i] <= p_c1[i-1];
        end
    end
    assign gad_c_0 = p_c0[LAT-1] ^ flip0;
    assign gad_c_1 = p_c1[LAT-1] ^ flip1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // One full transaction with out_ready high; flips applied for the sample edge
    task automatic run_txn(input logic a, input logic b, input logic [1:0] m,
                           input logic [2:0] f0, input logic [2:0] f1,
                           output logic c, output logic fault);
        int lat;
        @(negedge clk);
        bus.in_a = a; bus.in_b = b; bus.in_m = m;
        bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        chk("in_ready_idle", 32'(bus.in_ready), 32'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        chk("share_a0", 32'(gad_a_0), 32'({3{a ^ m[0]}}));
        chk("share_a1", 32'(gad_a_1), 32'({3{m[0]}}));
        chk("share_b0", 32'(gad_b_0), 32'({3{b ^ m[1]}}));
        chk("share_b1", 32'(gad_b_1), 32'({3{m[1]}}));
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
            if (lat == LAT) begin
                flip0 = f0; flip1 = f1;
            end
        end while (!bus.out_valid && lat < 20);
        flip0 = 3'b000; flip1 = 3'b000;
        chk("latency", 32'(lat), 32'(LAT + 1));
        chk("shares_zero_hold", 32'(gad_a_0 | gad_b_0 | gad_a_1 | gad_b_1), 32'd0);
        c = bus.out_c;
        fault = bus.out_fault;
        @(posedge clk); #1;
        chk("valid_one_cycle", 32'(bus.out_valid), 32'd0);
        chk("ready_after_hs", 32'(bus.in_ready), 32'd1);
    endtask

    typedef struct {
        logic       a;
        logic       b;
        logic [1:0] m;
        logic       exp_c;
    } vec_t;

    vec_t vecs [12];

    initial begin
        logic c, f;
        int   n;
        logic seen;

        vecs[0]  = '{1'b0, 1'b0, 2'b00, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 2'b00, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 2'b00, 1'b0};
        vecs[3]  = '{1'b1, 1'b1, 2'b00, 1'b1};
        vecs[4]  = '{1'b0, 1'b0, 2'b11, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 2'b11, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 2'b11, 1'b0};
        vecs[7]  = '{1'b1, 1'b1, 2'b11, 1'b1};
        vecs[8]  = '{1'b0, 1'b0, 2'b01, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 2'b01, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 2'b01, 1'b0};
        vecs[11] = '{1'b1, 1'b1, 2'b01, 1'b1};

        bus.in_valid = 1'b0; bus.in_a = 1'b0; bus.in_b = 1'b0;
        bus.in_m = 2'b00; bus.out_ready = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_gad", 32'({gad_a_0, gad_a_1, gad_b_0, gad_b_1}), 32'd0);
        chk("rst_cnt", 32'(fault_cnt), 32'd0);
        chk("rst_alarm", 32'(alarm), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // Fault-free table
        for (int i = 0; i < 12; i++) begin
            run_txn(vecs[i].a, vecs[i].b, vecs[i].m, 3'b000, 3'b000, c, f);
            $display("vec %0d a=%0b b=%0b m=%02b -> c=%0b fault=%0b", i,
                     vecs[i].a, vecs[i].b, vecs[i].m, c, f);
            chk("vec_c", 32'(c), 32'(vecs[i].exp_c));
            chk("vec_fault", 32'(f), 32'd0);
        end
        chk("cnt_clean", 32'(fault_cnt), 32'd0);
        chk("alarm_clean", 32'(alarm), 32'd0);

        // Single-replica flip: corrected value, flagged
        run_txn(1'b1, 1'b1, 2'b10, 3'b010, 3'b000, c, f);
        $display("single flip -> c=%0b fault=%0b cnt=%0d alarm=%0b", c, f, fault_cnt, alarm);
        chk("flip1_c", 32'(c), 32'd1);
        chk("flip1_fault", 32'(f), 32'd1);
        chk("flip1_cnt", 32'(fault_cnt), 32'd1);
        chk("flip1_alarm", 32'(alarm), 32'd1);

        // Two-replica flip on c1: majority wrong, result inverted, still flagged
        run_txn(1'b1, 1'b1, 2'b00, 3'b000, 3'b011, c, f);
        $display("double flip -> c=%0b fault=%0b cnt=%0d", c, f, fault_cnt);
        chk("flip2_c", 32'(c), 32'd0);
        chk("flip2_fault", 32'(f), 32'd1);
        chk("flip2_cnt", 32'(fault_cnt), 32'd2);

        // Back-pressure in HOLD with in_valid held high
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.in_a = 1'b1; bus.in_b = 1'b0; bus.in_m = 2'b01; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_a = 1'b1; bus.in_b = 1'b1; bus.in_m = 2'b00;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!bus.out_valid && n < 20);
        chk("stall_latency", 32'(n), 32'(LAT + 1));
        chk("stall_c", 32'(bus.out_c), 32'd0);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            chk("stall_valid", 32'(bus.out_valid), 32'd1);
            chk("stall_c_stable", 32'(bus.out_c), 32'd0);
            chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
            chk("stall_no_accept", 32'(gad_a_0), 32'd0);
        end
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        chk("stall_hs_valid", 32'(bus.out_valid), 32'd0);
        chk("stall_hs_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk); #1;
        chk("stall_next_accept_a", 32'(gad_a_0), 32'd7);
        chk("stall_next_accept_b", 32'(gad_b_0), 32'd7);
        chk("stall_next_busy", 32'(bus.in_ready), 32'd0);
        bus.in_valid = 1'b0;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!bus.out_valid && n < 20);
        chk("stall_second_lat", 32'(n), 32'(LAT + 1));
        chk("stall_second_c", 32'(bus.out_c), 32'd1);
        $display("stall sequence done, second result c=%0b", bus.out_c);
        @(posedge clk); #1;

        // Asynchronous reset in DRIVE drops the operation
        @(negedge clk);
        bus.in_a = 1'b1; bus.in_b = 1'b1; bus.in_m = 2'b11; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk); #2;
        reset = 1'b0;
        #1;
        chk("arst_gad", 32'({gad_a_0, gad_a_1, gad_b_0, gad_b_1}), 32'd0);
        chk("arst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("arst_out_c", 32'(bus.out_c), 32'd0);
        chk("arst_out_fault", 32'(bus.out_fault), 32'd0);
        chk("arst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("arst_cnt", 32'(fault_cnt), 32'd0);
        chk("arst_alarm", 32'(alarm), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        seen = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
            if (bus.out_valid) seen = 1'b1;
        end
        chk("arst_no_emit", 32'(seen), 32'd0);
        run_txn(1'b1, 1'b1, 2'b01, 3'b000, 3'b000, c, f);
        $display("post-reset txn -> c=%0b fault=%0b", c, f);
        chk("arst_next_c", 32'(c), 32'd1);
        chk("arst_next_fault", 32'(f), 32'd0);

        // Saturation of the fault counter
        for (int i = 0; i < 260; i++) begin
            logic [1:0] iv;
            iv = 2'(i);
            run_txn(iv[0], iv[1], 2'b00, 3'b100, 3'b000, c, f);
            chk("sat_fault", 32'(f), 32'd1);
            chk("sat_c", 32'(c), 32'(iv[0] & iv[1]));
            if (i == 254) chk("sat_cnt_255", 32'(fault_cnt), 32'd255);
        end
        $display("saturation -> cnt=%0d alarm=%0b", fault_cnt, alarm);
        chk("sat_cnt_final", 32'(fault_cnt), 32'd255);
        chk("sat_alarm", 32'(alarm), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
